mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the data word width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 17, giving the byte-address width in bits.
REQ-003 The block SHALL have parameter LATENCY, default 4, giving the cycles from request acceptance to response; legal range 1..15.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port mem_read, input, 1 bit: read request from the L1 cache.
REQ-007 The block SHALL have port mem_write, input, 1 bit: write request from the L1 cache.
REQ-008 The block SHALL have port address, input, ADDR_WIDTH bits: byte address of the request.
REQ-009 The block SHALL have port write_data, input, DATA_WIDTH bits: store data.
REQ-010 The block SHALL have port mem_ready, output, 1 bit: one-cycle response-complete pulse.
REQ-011 The block SHALL have port read_data, output, DATA_WIDTH bits: response data, valid while mem_ready=1.
REQ-012 The block SHALL have port busy, output, 1 bit: high while a request is outstanding.

Function
REQ-013 Storage SHALL be 2^(ADDR_WIDTH-2) words of DATA_WIDTH bits, indexed by address[ADDR_WIDTH-1:2].
REQ-014 The FSM SHALL have states IDLE, WAIT and RESP.
REQ-015 In IDLE, a rising edge with mem_read=1 or mem_write=1 SHALL latch address, write_data and request type, load the counter with LATENCY-1, and enter WAIT (LATENCY>1) or RESP (LATENCY=1).
REQ-016 In WAIT, the counter SHALL decrement each cycle; on the edge where it equals 1 the FSM SHALL enter RESP.
REQ-017 In RESP, mem_ready SHALL be 1 for exactly one cycle, and the FSM SHALL then return to IDLE.
REQ-018 A request sampled at edge N SHALL produce mem_ready=1 in the cycle following edge N+LATENCY-1 (LATENCY cycles after acceptance).
REQ-019 A write SHALL update storage on the edge entering RESP, and read_data SHALL then equal the written word.
REQ-020 A read SHALL load read_data from storage on the edge entering RESP.
REQ-021 read_data SHALL hold its last value outside RESP.
REQ-022 If mem_read and mem_write are high together, the request SHALL be treated as a write.
REQ-023 busy SHALL be 1 in WAIT and RESP, and 0 in IDLE.
REQ-024 Requests presented while busy=1 SHALL be ignored and not queued; the requester holds them until after mem_ready.
REQ-025 A request present in the IDLE cycle immediately after RESP SHALL be accepted, giving back-to-back service with no bubble.

Reset
REQ-026 rst_n=0 SHALL immediately force IDLE, mem_ready=0, busy=0, read_data=0 and counter=0, independent of clk.
REQ-027 A reset during WAIT or RESP SHALL abort the request, and an aborted write SHALL NOT modify storage.
REQ-028 Storage contents SHALL NOT be cleared by reset.

Configuration
REQ-029 With macro MEM_RESPONDER_ERR_EN defined, the block SHALL add output err, 1 bit, reset 0.
REQ-030 With MEM_RESPONDER_ERR_EN defined, err SHALL be 1 together with mem_ready when the latched address[1:0] is not 0.
REQ-031 With MEM_RESPONDER_ERR_EN defined, a misaligned write SHALL be suppressed and a misaligned read SHALL return 0.
REQ-032 Without MEM_RESPONDER_ERR_EN, port err SHALL NOT exist, address[1:0] SHALL be ignored, and all accesses SHALL be treated as aligned.

Verification
REQ-033 The bench SHALL cover: LATENCY=4, write 0xDEADBEEF to 0x00010 at edge 0 -> busy=1 in cycles 1-4, mem_ready=1 only in cycle 4, read_data=0xDEADBEEF.
REQ-034 The bench SHALL cover: read 0x00010 after REQ-033 -> mem_ready 4 cycles later with read_data=0xDEADBEEF; read of 0x00014 returns that word's prior content.
REQ-035 The bench SHALL cover: second request asserted during busy, held through mem_ready -> accepted in the first IDLE cycle, with exactly two mem_ready pulses in total.
REQ-036 The bench SHALL cover: mem_read=mem_write=1 with write_data=0x12345678 at 0x00020 -> write performed; a subsequent read returns 0x12345678.
REQ-037 The bench SHALL cover: rst_n pulsed low mid-WAIT of a write of 0xCAFEF00D to 0x00030 -> outputs 0 immediately, no mem_ready, and a later read returns the old value.
REQ-038 The bench SHALL cover, with MEM_RESPONDER_ERR_EN: write to 0x00031 -> err=1 with mem_ready, and the word at 0x00030 is unchanged.

Source files
------------

// File: rtl/mem_responder.sv
// Fixed-latency word memory that answers L1 read/write requests one at a time.
// Optional MEM_RESPONDER_ERR_EN adds an err output that flags and blocks misaligned accesses.
//
// state  | meaning
// IDLE   | waiting for a read or write request
// WAIT   | request latched, latency counter running
// RESP   | mem_ready pulse, read_data valid
module mem_responder #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 17,
   parameter int LATENCY    = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  mem_read,
   input  logic                  mem_write,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic [DATA_WIDTH-1:0] write_data,
   output logic                  mem_ready,
   output logic [DATA_WIDTH-1:0] read_data,
   output logic                  busy
`ifdef MEM_RESPONDER_ERR_EN
  ,output logic                  err
`endif
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;
   localparam int         DEPTH  = 1 << (ADDR_WIDTH - 2);

   logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

   logic [1:0]            state;
   logic [3:0]            cnt;
   logic [ADDR_WIDTH-3:0] idx_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic                  wr_q;

   logic                  req;
   logic                  enter_resp;
   logic                  misalign;
   logic [ADDR_WIDTH-3:0] cur_idx;
   logic [DATA_WIDTH-1:0] cur_wdata;
   logic                  cur_wr;
   logic                  do_write;

   assign req = mem_read | mem_write;

   // With LATENCY=1 the response edge is the acceptance edge, so use the live inputs in IDLE.
   assign cur_idx   = (state == S_IDLE) ? address[ADDR_WIDTH-1:2] : idx_q;
   assign cur_wdata = (state == S_IDLE) ? write_data : wdata_q;
   assign cur_wr    = (state == S_IDLE) ? mem_write : wr_q;

   assign enter_resp = ((state == S_IDLE) && req && (LATENCY == 1)) ||
                       ((state == S_WAIT) && (cnt == 4'd1));

`ifdef MEM_RESPONDER_ERR_EN
   logic [1:0] lo_q;
   logic [1:0] cur_lo;
   assign cur_lo   = (state == S_IDLE) ? address[1:0] : lo_q;
   assign misalign = (cur_lo != 2'b00);
`else
   logic unused_addr_lo;
   assign unused_addr_lo = ^address[1:0];
   assign misalign       = 1'b0;
`endif

   // rst_n gate keeps a write from landing on an edge where reset is held.
   assign do_write = rst_n && enter_resp && cur_wr && !misalign;

   assign busy      = (state != S_IDLE);
   assign mem_ready = (state == S_RESP);

   always_ff @(posedge clk) begin
      if (do_write) begin
         mem[cur_idx] <= cur_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         cnt       <= 4'd0;
         idx_q     <= '0;
         wdata_q   <= '0;
         wr_q      <= 1'b0;
         read_data <= '0;
`ifdef MEM_RESPONDER_ERR_EN
         lo_q      <= 2'b00;
         err       <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (req) begin
                  idx_q   <= address[ADDR_WIDTH-1:2];
                  wdata_q <= write_data;
                  wr_q    <= mem_write;
`ifdef MEM_RESPONDER_ERR_EN
                  lo_q    <= address[1:0];
`endif
                  cnt     <= 4'(LATENCY - 1);
                  state   <= (LATENCY > 1) ? S_WAIT : S_RESP;
               end
            end
            S_WAIT: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) begin
                  state <= S_RESP;
               end
            end
            S_RESP: state <= S_IDLE;
            default: state <= S_IDLE;
         endcase

         if (enter_resp) begin
            if (misalign) begin
               read_data <= '0;
            end else if (cur_wr) begin
               read_data <= cur_wdata;
            end else begin
               read_data <= mem[cur_idx];
            end
         end
`ifdef MEM_RESPONDER_ERR_EN
         err <= enter_resp && misalign;
`endif
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: an edge-counting response model checked every cycle,
// plus literal expectations for latency, data and pulse counts.
module tb_mem_responder;

   localparam int LAT = 4;
`ifdef MEM_RESPONDER_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        mem_read = 1'b0;
   logic        mem_write = 1'b0;
   logic [16:0] address = '0;
   logic [31:0] write_data = '0;
   logic        mem_ready;
   logic [31:0] read_data;
   logic        busy;
`ifdef MEM_RESPONDER_ERR_EN
   logic        err;
`endif

   mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(17), .LATENCY(LAT)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .mem_read(mem_read),
      .mem_write(mem_write),
      .address(address),
      .write_data(write_data),
      .mem_ready(mem_ready),
      .read_data(read_data),
      .busy(busy)
`ifdef MEM_RESPONDER_ERR_EN
     ,.err(err)
`endif
   );

   always #5 clk = ~clk;

   int pass_cnt = 0;
   int total    = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Response model: a request accepted at edge a answers after edge a+LAT-1,
   // the block is idle again from edge a+LAT, and can accept at edge a+LAT+1.
   logic [31:0] mmem [int];
   int          edge_n = 0;
   int          resp_edge = 0;
   bit          pend = 0;
   bit          p_wr = 0;
   logic [16:0] p_addr = '0;
   logic [31:0] p_data = '0;
   logic        m_ready = 0, m_busy = 0, m_err = 0;
   logic [31:0] m_rdata = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend = 0; m_ready = 0; m_busy = 0; m_err = 0; m_rdata = '0;
      end else begin
         edge_n++;
         if (pend && edge_n == resp_edge + 1) pend = 0;
         else if (!pend && (mem_read || mem_write)) begin
            pend = 1; resp_edge = edge_n + LAT - 1;
            p_wr = mem_write; p_addr = address; p_data = write_data;
         end
         m_ready = pend && (edge_n == resp_edge);
         m_err   = 0;
         if (m_ready) begin
            if (ERR_EN && p_addr[1:0] != 2'b00) begin
               m_rdata = '0; m_err = 1;
            end else if (p_wr) begin
               mmem[int'(p_addr >> 2)] = p_data; m_rdata = p_data;
            end else begin
               m_rdata = mmem.exists(int'(p_addr >> 2)) ? mmem[int'(p_addr >> 2)] : 32'h0;
            end
         end
         m_busy = pend;
      end
   end

   always @(negedge clk) begin
      chk("ready", {31'b0, mem_ready}, {31'b0, m_ready});
      chk("busy", {31'b0, busy}, {31'b0, m_busy});
      chk("rdata", read_data, m_rdata);
`ifdef MEM_RESPONDER_ERR_EN
      chk("err", {31'b0, err}, {31'b0, m_err});
`endif
   end

   task automatic issue(input logic rd, input logic wr, input logic [16:0] a, input logic [31:0] d);
      @(negedge clk);
      mem_read = rd; mem_write = wr; address = a; write_data = d;
      @(negedge clk);
      mem_read = 1'b0; mem_write = 1'b0;
   endtask

   // Called at the negedge after the accepting edge; lat counts further edges until mem_ready.
   task automatic wait_ready(output int lat, output logic [31:0] d);
      lat = -1; d = '0;
      for (int i = 0; i < 20; i++) begin
         if (mem_ready) begin lat = i; d = read_data; break; end
         @(negedge clk);
      end
      if (lat < 0) begin
         total++;
         $display("FAIL ready_timeout: no mem_ready within 20 cycles at %0t", $time);
      end
      @(negedge clk);
   endtask

   task automatic access(input string name, input logic rd, input logic wr, input logic [16:0] a,
                         input logic [31:0] d, input logic [31:0] exp_data);
      int          lat;
      logic [31:0] got;
      issue(rd, wr, a, d);
      wait_ready(lat, got);
      chk({name, "_lat"}, 32'(lat), 32'(LAT - 1));
      chk({name, "_data"}, got, exp_data);
   endtask

   initial begin
      int drop_at;
      int pulses;

      @(negedge clk);
      chk("rst_ready", {31'b0, mem_ready}, 32'h0);
      chk("rst_busy", {31'b0, busy}, 32'h0);
      chk("rst_rdata", read_data, 32'h0);
      #2 rst_n = 1'b1;

      access("pre14", 1'b0, 1'b1, 17'h00014, 32'h11112222, 32'h11112222);
      access("pre30", 1'b0, 1'b1, 17'h00030, 32'h0BADC0DE, 32'h0BADC0DE);

      // Write at edge 0: busy from the first cycle, ready three edges later.
      issue(1'b0, 1'b1, 17'h00010, 32'hDEADBEEF);
      begin
         int lat; logic [31:0] got;
         wait_ready(lat, got);
         chk("wr10_lat", 32'(lat), 32'd3);
         chk("wr10_data", got, 32'hDEADBEEF);
      end
      access("rd10", 1'b1, 1'b0, 17'h00010, 32'h0, 32'hDEADBEEF);
      access("rd14", 1'b1, 1'b0, 17'h00014, 32'h0, 32'h11112222);

      // Second request held through busy, dropped once accepted at the first IDLE edge.
      @(negedge clk);
      mem_read = 1'b1; address = 17'h00010;
      @(negedge clk);
      mem_read = 1'b0; mem_write = 1'b1; address = 17'h00040; write_data = 32'h5555AAAA;
      drop_at = -1; pulses = 0;
      for (int i = 0; i < 25; i++) begin
         if (mem_ready) begin
            pulses++;
            if (drop_at < 0) drop_at = i + 2;
         end
         if (i == drop_at) mem_write = 1'b0;
         @(negedge clk);
      end
      mem_write = 1'b0;
      chk("b2b_pulses", 32'(pulses), 32'd2);
      access("rd40", 1'b1, 1'b0, 17'h00040, 32'h0, 32'h5555AAAA);

      access("both20", 1'b1, 1'b1, 17'h00020, 32'h12345678, 32'h12345678);
      access("rd20", 1'b1, 1'b0, 17'h00020, 32'h0, 32'h12345678);

      // Reset mid-WAIT aborts the write.
      issue(1'b0, 1'b1, 17'h00030, 32'hCAFEF00D);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_ready", {31'b0, mem_ready}, 32'h0);
      chk("abort_busy", {31'b0, busy}, 32'h0);
      chk("abort_rdata", read_data, 32'h0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (mem_ready) pulses++;
      end
      chk("abort_pulses", 32'(pulses), 32'd0);
      access("rd30", 1'b1, 1'b0, 17'h00030, 32'h0, 32'h0BADC0DE);

`ifdef MEM_RESPONDER_ERR_EN
      issue(1'b0, 1'b1, 17'h00031, 32'hFFFF0000);
      begin
         int lat; logic [31:0] got;
         for (int i = 0; i < 20 && !mem_ready; i++) @(negedge clk);
         chk("mis_err", {31'b0, err}, 32'h1);
         chk("mis_ready", {31'b0, mem_ready}, 32'h1);
         @(negedge clk);
         lat = 0; got = '0;
      end
      access("rd30b", 1'b1, 1'b0, 17'h00030, 32'h0, 32'h0BADC0DE);
`endif

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
